jump_sequencer: RTL and testbench

Frame-rate controller that sequences the player's vertical jump motion during gameplay. Detects the jump key edge on the keyboard keycode bus, steps through a fixed velocity profile one frame tick at a time and drives the signed per-frame Y-displacement consumed by the ball/player motion datapath. Gated by the game-state FSM outputs: `gameplay`, `pause` and `internal_reset`.

---
 rtl/jump_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_jump_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_sequencer.sv
// jump_sequencer: steps the player's vertical jump velocity profile once per frame tick.
// Define JUMP_SEQ_BUFFER_EN to remember a mid-jump key press and relaunch on landing.
module jump_sequencer #(
    parameter logic [7:0]  JUMP_KEY      = 8'h1A,
    parameter int unsigned HOLD_FRAMES   = 2,
    parameter int unsigned BUFFER_FRAMES = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       gameplay,
    input  logic       pause,
    input  logic       internal_reset,
    output logic [7:0] jump_motion,
    output logic       airborne,
    output logic       jump_start,
    output logic       landed
);
    localparam int unsigned STEP_W   = 3;
    localparam int unsigned HOLD_W   = 4;
    localparam int unsigned BUF_W    = 4;
    localparam int unsigned MOTION_W = 8;

    localparam logic [STEP_W-1:0] PEAK_STEP = STEP_W'(3);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(6);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    generate
        if (HOLD_FRAMES == 0 || HOLD_FRAMES > 15) begin : g_bad_hold
            $error("HOLD_FRAMES must be in 1..15");
        end
        if (BUFFER_FRAMES == 0 || BUFFER_FRAMES > 15) begin : g_bad_buffer
            $error("BUFFER_FRAMES must be in 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, RISE, PEAK, FALL, LAND} state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                req_q, req_d;
    logic                key_prev_q;
    logic                key_hit;
    logic                key_edge;
    logic                clear;
    logic [MOTION_W-1:0] motion_d;
    logic                airborne_d;
    logic                start_d;
    logic                landed_d;
`ifdef JUMP_SEQ_BUFFER_EN
    logic [BUF_W-1:0]    buf_q, buf_d;
`endif

    // Signed per-frame displacement for each profile step; negative is up.
    function automatic logic [MOTION_W-1:0] profile(input logic [STEP_W-1:0] step);
        case (step)
            3'd0:    profile = MOTION_W'(-10);
            3'd1:    profile = MOTION_W'(-6);
            3'd2:    profile = MOTION_W'(-3);
            3'd4:    profile = MOTION_W'(3);
            3'd5:    profile = MOTION_W'(6);
            3'd6:    profile = MOTION_W'(10);
            default: profile = '0;
        endcase
    endfunction

    function automatic state_t step_state(input logic [STEP_W-1:0] step);
        if (step < PEAK_STEP)       step_state = RISE;
        else if (step == PEAK_STEP) step_state = PEAK;
        else                        step_state = FALL;
    endfunction

    // Next-state and registered-output values.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        hold_d   = hold_q;
        req_d    = req_q;
        start_d  = 1'b0;
        landed_d = 1'b0;
`ifdef JUMP_SEQ_BUFFER_EN
        buf_d    = buf_q;
`endif
        key_hit  = (keycode == JUMP_KEY);
        key_edge = key_hit && !key_prev_q;
        clear    = internal_reset || (!pause && !gameplay);

        if (clear) begin
            state_d = IDLE;
            step_d  = '0;
            hold_d  = '0;
            req_d   = 1'b0;
`ifdef JUMP_SEQ_BUFFER_EN
            buf_d   = '0;
`endif
        end else if (pause) begin
            req_d = 1'b0;
        end else begin
`ifdef JUMP_SEQ_BUFFER_EN
            if (key_edge && state_q != IDLE) begin
                buf_d = BUF_W'(BUFFER_FRAMES);
            end else if (frame_tick && state_q != LAND && buf_q != '0) begin
                buf_d = buf_q - BUF_W'(1);
            end
`endif
            case (state_q)
                IDLE: begin
                    if (frame_tick && (req_q || key_edge)) begin
                        state_d = RISE;
                        step_d  = '0;
                        hold_d  = '0;
                        req_d   = 1'b0;
                        start_d = 1'b1;
                    end else if (key_edge) begin
                        req_d = 1'b1;
                    end
                end
                RISE, PEAK, FALL: begin
                    if (frame_tick) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d = '0;
                            if (step_q == LAST_STEP) begin
                                state_d  = LAND;
                                landed_d = 1'b1;
                            end else begin
                                step_d  = step_q + STEP_W'(1);
                                state_d = step_state(step_d);
                            end
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                LAND: begin
                    if (frame_tick) begin
                        state_d = IDLE;
                        step_d  = '0;
                        hold_d  = '0;
`ifdef JUMP_SEQ_BUFFER_EN
                        // A press on this very tick counts as buffered too.
                        if (buf_q != '0 || key_edge) begin
                            state_d = RISE;
                            start_d = 1'b1;
                            buf_d   = '0;
                        end
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end

        airborne_d = (state_d == RISE) || (state_d == PEAK) || (state_d == FALL);
        motion_d   = airborne_d ? profile(step_d) : '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            hold_q      <= '0;
            req_q       <= 1'b0;
            key_prev_q  <= 1'b0;
            jump_motion <= '0;
            airborne    <= 1'b0;
            jump_start  <= 1'b0;
            landed      <= 1'b0;
`ifdef JUMP_SEQ_BUFFER_EN
            buf_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            hold_q      <= hold_d;
            req_q       <= req_d;
            key_prev_q  <= key_hit;
            jump_motion <= motion_d;
            airborne    <= airborne_d;
            jump_start  <= start_d;
            landed      <= landed_d;
`ifdef JUMP_SEQ_BUFFER_EN
            buf_q       <= buf_d;
`endif
        end
    end

endmodule

// File: tb/tb_jump_sequencer.sv
// tb_jump_sequencer: directed and randomized checks of jump_sequencer against a
// tick-age reference model (ticks elapsed since launch rather than state/step/hold).
module tb_jump_sequencer;
    localparam logic [7:0] KEY  = 8'h1A;
    localparam int         H    = 2;
    localparam int         BUFN = 4;
    localparam int         AIR  = 7 * H;
`ifdef JUMP_SEQ_BUFFER_EN
    localparam bit         BUF_EN = 1'b1;
`else
    localparam bit         BUF_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_tick;
    logic [7:0] keycode;
    logic       gameplay;
    logic       pause;
    logic       internal_reset;
    logic [7:0] jump_motion;
    logic       airborne;
    logic       jump_start;
    logic       landed;

    jump_sequencer #(
        .JUMP_KEY      (KEY),
        .HOLD_FRAMES   (H),
        .BUFFER_FRAMES (BUFN)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_tick     (frame_tick),
        .keycode        (keycode),
        .gameplay       (gameplay),
        .pause          (pause),
        .internal_reset (internal_reset),
        .jump_motion    (jump_motion),
        .airborne       (airborne),
        .jump_start     (jump_start),
        .landed         (landed)
    );

    always #5 Clk = ~Clk;

    int prof[7] = '{-10, -6, -3, 0, 3, 6, 10};
    int exp1[16] = '{-10, -10, -6, -6, -3, -3, 0, 0, 3, 3, 6, 6, 10, 10, 0, 0};

    // Reference model: a jump is just "ticks since launch"; AIR ticks later it lands.
    bit m_active;
    int m_age;
    bit m_req;
    int m_buf;
    bit m_kprev;
    int e_motion;
    bit e_air;
    bit e_start;
    bit e_landed;

    int n_checks = 0;
    int n_errors = 0;
    int starts_seen = 0;
    int lands_seen = 0;
    int got[16];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_age = 0; m_req = 1'b0; m_buf = 0; m_kprev = 1'b0;
        e_motion = 0; e_air = 1'b0; e_start = 1'b0; e_landed = 1'b0;
    endtask

    task automatic model_edge(input bit tick, input bit hit, input bit gp, input bit ps, input bit ir);
        bit edge_k;
        bit idle;
        bit in_land;
        edge_k   = hit && !m_kprev;
        m_kprev  = hit;
        e_start  = 1'b0;
        e_landed = 1'b0;
        if (ir || (!ps && !gp)) begin
            m_active = 1'b0; m_age = 0; m_req = 1'b0; m_buf = 0;
        end else if (ps) begin
            m_req = 1'b0;
        end else begin
            idle    = !m_active;
            in_land = m_active && (m_age == AIR);
            if (BUF_EN) begin
                if (edge_k && !idle) m_buf = BUFN;
                else if (tick && !in_land && m_buf > 0) m_buf--;
            end
            if (idle) begin
                if (tick && (m_req || edge_k)) begin
                    m_active = 1'b1; m_age = 0; m_req = 1'b0; e_start = 1'b1;
                end else if (edge_k) begin
                    m_req = 1'b1;
                end
            end else if (tick) begin
                if (in_land) begin
                    if (BUF_EN && m_buf > 0) begin
                        m_age = 0; m_buf = 0; e_start = 1'b1;
                    end else begin
                        m_active = 1'b0; m_age = 0;
                    end
                end else begin
                    m_age++;
                    if (m_age == AIR) e_landed = 1'b1;
                end
            end
        end
        e_air    = m_active && (m_age < AIR);
        e_motion = e_air ? prof[m_age / H] : 0;
    endtask

    // One clock: drive on the falling edge, step the model at the rising edge, compare 1 after.
    task automatic cyc(input bit tick, input logic [7:0] key, input bit gp, input bit ps, input bit ir);
        @(negedge Clk);
        frame_tick = tick; keycode = key; gameplay = gp; pause = ps; internal_reset = ir;
        @(posedge Clk);
        model_edge(tick, key == KEY, gp, ps, ir);
        #1;
        check_eq("jump_motion", int'($signed(jump_motion)), e_motion);
        check_eq("airborne", int'(airborne), int'(e_air));
        check_eq("jump_start", int'(jump_start), int'(e_start));
        check_eq("landed", int'(landed), int'(e_landed));
        starts_seen += int'(jump_start);
        lands_seen  += int'(landed);
    endtask

    task automatic play_frame(input logic [7:0] key);
        cyc(1'b1, key, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, key, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, key, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic settle();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // Launch, then press again n ticks before landing and see whether it relaunches.
    task automatic late_key(input int n, input int exp_relaunch);
        int s0;
        cyc(1'b1, KEY, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (AIR - n) play_frame(8'h00);
        cyc(1'b0, KEY, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (n) play_frame(8'h00);
        check_eq("late_key_in_land", int'(airborne), 0);
        s0 = starts_seen;
        play_frame(8'h00);
        check_eq("late_key_relaunch", starts_seen - s0, exp_relaunch);
        check_eq("late_key_airborne", int'(airborne), exp_relaunch);
        settle();
    endtask

    int  sum;
    int  s0;
    int  l0;
    int  land_at;
    bit  tk, gp, ps, ir;
    logic [7:0] kc;

    initial begin
        Reset_n = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
        gameplay = 1'b1; pause = 1'b0; internal_reset = 1'b0;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        check_eq("reset_motion", int'($signed(jump_motion)), 0);
        check_eq("reset_airborne", int'(airborne), 0);
        check_eq("reset_start", int'(jump_start), 0);
        check_eq("reset_landed", int'(landed), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Full jump from a key edge that precedes the tick.
        s0 = starts_seen; l0 = lands_seen; sum = 0; land_at = -1;
        cyc(1'b0, KEY, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 16; t++) begin
            play_frame(8'h00);
            got[t] = int'($signed(jump_motion));
            sum += got[t];
            if (land_at < 0 && lands_seen != l0) land_at = t;
        end
        for (int t = 0; t < 16; t++) check_eq($sformatf("profile[%0d]", t), got[t], exp1[t]);
        check_eq("profile_sum", sum, 0);
        check_eq("profile_starts", starts_seen - s0, 1);
        check_eq("profile_lands", lands_seen - l0, 1);
        check_eq("landed_tick", land_at, AIR);

        // Key edge and tick together, then pause at step 2.
        cyc(1'b1, KEY, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_eq("same_cycle_start", int'($signed(jump_motion)), -10);
        repeat (4) play_frame(8'h00);
        check_eq("step2_motion", int'($signed(jump_motion)), -3);
        repeat (5) begin
            cyc(1'b1, KEY, 1'b1, 1'b1, 1'b0);
            cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        end
        check_eq("pause_hold_motion", int'($signed(jump_motion)), -3);
        play_frame(8'h00);
        check_eq("resume_same_hold", int'($signed(jump_motion)), -3);
        play_frame(8'h00);
        check_eq("resume_next_step", int'($signed(jump_motion)), 0);
        settle();

        // internal_reset at step 5.
        cyc(1'b1, KEY, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (10) play_frame(8'h00);
        check_eq("step5_motion", int'($signed(jump_motion)), 6);
        l0 = lands_seen;
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check_eq("ireset_motion", int'($signed(jump_motion)), 0);
        check_eq("ireset_airborne", int'(airborne), 0);
        repeat (8) play_frame(8'h00);
        check_eq("ireset_no_land", lands_seen - l0, 0);

        // Held key launches once only.
        settle();
        s0 = starts_seen;
        repeat (40) play_frame(KEY);
        check_eq("held_key_starts", starts_seen - s0, 1);
        settle();

        // Jump buffer window.
        late_key(2, BUF_EN ? 1 : 0);
        late_key(6, 0);

        // Asynchronous reset mid-cycle during RISE.
        cyc(1'b1, KEY, 1'b1, 1'b0, 1'b0);
        check_eq("pre_areset_start", int'(jump_start), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_eq("areset_motion", int'($signed(jump_motion)), 0);
        check_eq("areset_airborne", int'(airborne), 0);
        check_eq("areset_start", int'(jump_start), 0);
        check_eq("areset_landed", int'(landed), 0);
        model_reset();
        keycode = 8'h00; frame_tick = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;

        // Randomized traffic against the model.
        kc = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            tk = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) kc = ($urandom_range(0, 1) == 1) ? KEY : 8'($urandom_range(0, 255));
            gp = ($urandom_range(0, 99) != 0);
            ps = ($urandom_range(0, 24) == 0);
            ir = ($urandom_range(0, 199) == 0);
            cyc(tk, kc, gp, ps, ir);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
